// File: rtl/sa_act_skew.sv
// Activation skew feeder: delays row r by r cycles (plus one output register) to form a diagonal wavefront.
// Optional macro SA_ACT_SKEW_CNT_EN adds o_vec_count, the saturating per-tile accepted-vector count.
module sa_act_skew #(
    parameter int MUL_DATAWIDTH = 8,
    parameter int NUM_ROWS      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [MUL_DATAWIDTH-1:0] i_act_vec [NUM_ROWS],
    input  logic                     i_last,
    output logic [MUL_DATAWIDTH-1:0] o_act [NUM_ROWS],
    output logic [NUM_ROWS-1:0]      o_act_valid,
    output logic                     o_busy,
    output logic                     o_done
`ifdef SA_ACT_SKEW_CNT_EN
    ,
    output logic [15:0]              o_vec_count
`endif
);

    localparam int CNT_W = $clog2(NUM_ROWS);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(NUM_ROWS - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             done_next;
    logic             accept;

    assign accept = i_valid && o_ready;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            o_done <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            o_done <= done_next;
        end
    end

    // Next-state logic; the drain ends so that IDLE is entered with the counter at zero.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        case (state)
            IDLE, STREAM: begin
                if (accept) begin
                    if (i_last) begin
                        state_next = DRAIN;
                        cnt_next   = DRAIN_LOAD;
                    end else begin
                        state_next = STREAM;
                    end
                end
            end
            DRAIN: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: depends on state only, so o_ready has no combinational path from i_valid.
    always_comb begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
        case (state)
            IDLE:    begin o_ready = 1'b1; o_busy = 1'b0; end
            STREAM:  begin o_ready = 1'b1; o_busy = 1'b1; end
            DRAIN:   begin o_ready = 1'b0; o_busy = 1'b1; end
            default: begin o_ready = 1'b1; o_busy = 1'b0; end
        endcase
    end

    // Skew line: row r has r+1 register stages; non-accept cycles inject a zero bubble.
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        logic [MUL_DATAWIDTH-1:0] dat [r+1];
        logic                     vld [r+1];

        always_ff @(posedge clk) begin
            // NOTE: these stages are reset explicitly; stale data must never reach the array after reset.
            if (rst) begin
                for (int i = 0; i <= r; i++) begin
                    dat[i] <= '0;
                    vld[i] <= 1'b0;
                end
            end else begin
                dat[0] <= accept ? i_act_vec[r] : '0;
                vld[0] <= accept;
                for (int i = 1; i <= r; i++) begin
                    dat[i] <= dat[i-1];
                    vld[i] <= vld[i-1];
                end
            end
        end

        assign o_act[r]       = dat[r];
        assign o_act_valid[r] = vld[r];
    end

`ifdef SA_ACT_SKEW_CNT_EN
    // First accept from IDLE starts a new tile at 1; otherwise count up and saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_vec_count <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                o_vec_count <= 16'd1;
            end else if (o_vec_count != 16'hFFFF) begin
                o_vec_count <= o_vec_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sa_act_skew.sv
// Directed bench for sa_act_skew (NUM_ROWS=4): table-driven cycle vectors plus hand sequences.
// Define SA_ACT_SKEW_CNT_EN to also exercise o_vec_count.
module tb_sa_act_skew;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_act_vec [N];
    logic         i_last;
    logic [W-1:0] o_act [N];
    logic [N-1:0] o_act_valid;
    logic         o_busy;
    logic         o_done;
`ifdef SA_ACT_SKEW_CNT_EN
    logic [15:0]  o_vec_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sa_act_skew #(.MUL_DATAWIDTH(W), .NUM_ROWS(N)) dut (
        .clk(clk),
        .rst(rst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_act_vec(i_act_vec),
        .i_last(i_last),
        .o_act(o_act),
        .o_act_valid(o_act_valid),
        .o_busy(o_busy),
        .o_done(o_done)
`ifdef SA_ACT_SKEW_CNT_EN
        ,
        .o_vec_count(o_vec_count)
`endif
    );

    typedef struct {
        logic        valid;
        logic        last;
        logic [31:0] vec;      // {row3,row2,row1,row0}
        logic [31:0] exp_act;  // {row3,row2,row1,row0}
        logic [3:0]  exp_vld;
        logic        exp_ready;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_act();
        logic [31:0] p;
        for (int r = 0; r < N; r++) p[r*W +: W] = o_act[r];
        return p;
    endfunction

    task automatic drive(input logic v, input logic l, input logic [31:0] vec);
        i_valid = v;
        i_last  = l;
        for (int r = 0; r < N; r++) i_act_vec[r] = vec[r*W +: W];
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [15];

    initial begin
        int done_cnt;
        int done_cyc;

        // Single vector {1,2,3,4} with i_last
        tbl[0]  = '{1'b1, 1'b1, 32'h04030201, 32'h00000000, 4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,        32'h00000001, 4'b0001, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,        32'h00000200, 4'b0010, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,        32'h00030000, 4'b0100, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,        32'h04000000, 4'b1000, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,        32'h00000000, 4'b0000, 1'b1, 1'b0, 1'b0};
        // Bubble: v0, two idle cycles, v1 with i_last
        tbl[6]  = '{1'b1, 1'b0, 32'h14131211, 32'h00000000, 4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,        32'h00000011, 4'b0001, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 32'hDEADBEEF, 32'h00001200, 4'b0010, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 32'h24232221, 32'h00130000, 4'b0100, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,        32'h14000021, 4'b1001, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,        32'h00002200, 4'b0010, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 32'h0,        32'h00230000, 4'b0100, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 32'h0,        32'h24000000, 4'b1000, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 32'h0,        32'h00000000, 4'b0000, 1'b1, 1'b0, 1'b0};

        // Reset
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        step();
        step();
        check("reset_act",   pack_act(),         32'h0);
        check("reset_vld",   32'(o_act_valid),   32'h0);
        check("reset_ready", 32'(o_ready),       32'h1);
        check("reset_busy",  32'(o_busy),        32'h0);
        check("reset_done",  32'(o_done),        32'h0);
        rst = 1'b0;

        // Table-driven cycles
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].valid, tbl[i].last, tbl[i].vec);
            check($sformatf("tbl%0d_act", i),   pack_act(),        tbl[i].exp_act);
            check($sformatf("tbl%0d_vld", i),   32'(o_act_valid),  32'(tbl[i].exp_vld));
            check($sformatf("tbl%0d_ready", i), 32'(o_ready),      32'(tbl[i].exp_ready));
            check($sformatf("tbl%0d_busy", i),  32'(o_busy),       32'(tbl[i].exp_busy));
            check($sformatf("tbl%0d_done", i),  32'(o_done),       32'(tbl[i].exp_done));
            step();
        end

        // Continuous stream v0..v5, row r of vk = k*16 + r
        done_cnt = 0;
        done_cyc = -1;
        for (int c = 0; c < 12; c++) begin
            if (c <= 5) drive(1'b1, c == 5, {8'(c*16+3), 8'(c*16+2), 8'(c*16+1), 8'(c*16)});
            else        drive(1'b0, 1'b0, 32'h0);
            if (c >= 3 && c <= 8) begin
                check($sformatf("stream_row2_c%0d", c), 32'(o_act[2]), 32'((c-3)*16 + 2));
                check($sformatf("stream_vld2_c%0d", c), 32'(o_act_valid[2]), 32'h1);
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = c;
            end
            step();
        end
        check("stream_done_count", 32'(done_cnt), 32'd1);
        check("stream_done_cycle", 32'(done_cyc), 32'd9);

        // Back-pressure: A with i_last, then B held valid through the drain
        drive(1'b1, 1'b1, 32'hA3A2A1A0);
        step();
        drive(1'b1, 1'b1, 32'hB3B2B1B0);
        for (int c = 1; c <= 4; c++) begin
            if (c <= 3) check($sformatf("bp_ready_c%0d", c), 32'(o_ready), 32'h0);
            if (c >= 2) check($sformatf("bp_row0_vld_c%0d", c), 32'(o_act_valid[0]), 32'h0);
            if (c == 4) begin
                check("bp_done_c4",  32'(o_done),  32'h1);
                check("bp_ready_c4", 32'(o_ready), 32'h1);
            end
            step();
        end
        drive(1'b0, 1'b0, 32'h0);
        check("bp_b_row0",     32'(o_act[0]),       32'hB0);
        check("bp_b_row0_vld", 32'(o_act_valid[0]), 32'h1);
        check("bp_b_busy",     32'(o_busy),         32'h1);
        for (int c = 0; c < 5; c++) step();
        check("bp_idle_ready", 32'(o_ready), 32'h1);
        check("bp_idle_busy",  32'(o_busy),  32'h0);

        // Reset one cycle into DRAIN
        drive(1'b1, 1'b1, 32'h44332211);
        step();
        drive(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstdrain_act",   pack_act(),       32'h0);
        check("rstdrain_vld",   32'(o_act_valid), 32'h0);
        check("rstdrain_busy",  32'(o_busy),      32'h0);
        check("rstdrain_ready", 32'(o_ready),     32'h1);
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (o_done) done_cnt++;
            step();
        end
        check("rstdrain_no_done", 32'(done_cnt), 32'd0);

        // Reset wins over a simultaneous accept
        drive(1'b1, 1'b0, 32'h55555555);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        check("rst_accept_busy", 32'(o_busy), 32'h0);
        step();
        check("rst_accept_vld",  32'(o_act_valid), 32'h0);

`ifdef SA_ACT_SKEW_CNT_EN
        // Vector counter: three-vector tile, then first accept of the next tile
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, c == 2, 32'h01010101);
            step();
        end
        drive(1'b0, 1'b0, 32'h0);
        for (int c = 3; c < 6; c++) step();
        check("cnt_done_flag", 32'(o_done),      32'h1);
        check("cnt_at_done",   32'(o_vec_count), 32'd3);
        drive(1'b1, 1'b0, 32'h02020202);
        step();
        drive(1'b0, 1'b0, 32'h0);
        check("cnt_next_tile", 32'(o_vec_count), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
